// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single unified memory port between the instruction-fetch path
// (i_*) and the load/store/AMO path (d_*). Transactions are serialised with a
// fixed data-first priority. A starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive data grants taken while fetch was waiting.
//
// Optional feature (compile-time macro MEM_ARB_LOCK_EN):
//   A data completion with d_lock=1 locks the bus to the data port. While
//   locked, only data is granted and the starvation override is suppressed.
//   The starvation counter saturates at STARVE_LIMIT. A data completion with
//   d_lock=0 releases the lock. Without the macro, d_lock is ignored.
//
// Parameters:
//   ADDR_W        address width
//   DATA_W        data width (strobe width is DATA_W/8)
//   STARVE_LIMIT  max consecutive data grants while fetch waits (>= 1)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_req/i_addr             fetch request and address (held until i_ready)
//   i_rdata/i_ready          fetch read data and completion pulse
//   d_req/d_wen/d_strb       data request, write enable, byte strobes
//   d_addr/d_wdata/d_lock    data address, write data, lock-after-this flag
//   d_rdata/d_ready          data read data and completion pulse
//   m_req/m_wen/m_strb       memory request, write enable, strobes (registered)
//   m_addr/m_wdata           memory address and write data (registered)
//   m_rdata/m_ready          memory read data and completion
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ready,
    input  logic                d_req,
    input  logic                d_wen,
    input  logic [DATA_W/8-1:0] d_strb,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic                d_lock,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                m_req,
    output logic                m_wen,
    output logic [DATA_W/8-1:0] m_strb,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   starve_cnt_reg;
    logic               starved;
    logic               locked;
    logic               grant_i;
    logic               grant_d;
    logic               in_idle;

    logic               m_wen_reg;
    logic [STRB_W-1:0]  m_strb_reg;
    logic [ADDR_W-1:0]  m_addr_reg;
    logic [DATA_W-1:0]  m_wdata_reg;

    // -------------------------------------------------------------------------
    // Optional bus lock
    // -------------------------------------------------------------------------
`ifdef MEM_ARB_LOCK_EN
    logic lock_reg;

    // The lock follows d_lock of whichever data transaction completes last.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_reg <= 1'b0;
        end else if (state_reg == D_BUSY && m_ready) begin
            lock_reg <= d_lock;
        end
    end

    assign locked = lock_reg;
`else
    logic unused_d_lock;
    assign unused_d_lock = d_lock;
    assign locked        = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Arbitration decision (only acted upon while IDLE)
    // -------------------------------------------------------------------------
    assign in_idle = (state_reg == IDLE);
    assign starved = (starve_cnt_reg == LIMIT_CNT);

    // Fetch wins when it is alone, or when it has been starved; a held lock
    // keeps it out entirely, even if the data port is not requesting.
    assign grant_i = in_idle && i_req && !locked && (!d_req || starved);
    assign grant_d = in_idle && d_req && !grant_i;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_d) begin
                    state_next = D_BUSY;
                end else if (grant_i) begin
                    state_next = I_BUSY;
                end
            end
            // Always pass through IDLE after a completion so a requester's
            // still-high req in its own completion cycle is never re-granted.
            I_BUSY, D_BUSY: begin
                if (m_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        m_req   = (state_reg == I_BUSY) || (state_reg == D_BUSY);
        i_ready = (state_reg == I_BUSY) && m_ready;
        d_ready = (state_reg == D_BUSY) && m_ready;
    end

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    assign m_wen   = m_wen_reg;
    assign m_strb  = m_strb_reg;
    assign m_addr  = m_addr_reg;
    assign m_wdata = m_wdata_reg;

    // -------------------------------------------------------------------------
    // Memory-side payload, captured once at the granting edge and then held
    // regardless of what the requester does with its payload afterwards.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            m_wen_reg   <= 1'b0;
            m_strb_reg  <= '0;
            m_addr_reg  <= '0;
            m_wdata_reg <= '0;
        end else if (grant_d) begin
            m_wen_reg   <= d_wen;
            m_strb_reg  <= d_strb;
            m_addr_reg  <= d_addr;
            m_wdata_reg <= d_wdata;
        end else if (grant_i) begin
            m_wen_reg   <= 1'b0;
            m_strb_reg  <= '0;
            m_addr_reg  <= i_addr;
            m_wdata_reg <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Starvation counter: counts data grants taken while fetch was waiting.
    // Saturation only matters with the lock, where data may keep winning
    // past the limit.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else if (grant_i) begin
            starve_cnt_reg <= '0;
        end else if (grant_d) begin
            if (!i_req) begin
                starve_cnt_reg <= '0;
            end else if (starve_cnt_reg != LIMIT_CNT) begin
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Single transactions come from a vector
// table; grant ordering, starvation, lock and reset cases are hand-written
// sequences. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam logic [31:0] I_ADDR = 32'h0000_0100;
    localparam logic [31:0] D_ADDR = 32'h0000_2000;

    logic        tb_clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic        d_wen;
    logic [3:0]  d_strb;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_lock;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_req;
    logic        m_wen;
    logic [3:0]  m_strb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;

    // Memory model: either answers in the first busy cycle (auto) or follows
    // a manually driven ready.
    logic        mem_auto;
    logic        m_ready_man;
    assign m_ready = mem_auto ? m_req : m_ready_man;

    int n_checks = 0;
    int n_errors = 0;
    bit grant_is_i [0:15];

    mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk     (tb_clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ready (i_ready),
        .d_req   (d_req),
        .d_wen   (d_wen),
        .d_strb  (d_strb),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_lock  (d_lock),
        .d_rdata (d_rdata),
        .d_ready (d_ready),
        .m_req   (m_req),
        .m_wen   (m_wen),
        .m_strb  (m_strb),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_wen;
        logic [3:0]  d_strb;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        int          wait_cyc;   // busy cycles with m_ready=0 before completion
        logic [31:0] rdata;
        logic        exp_i;      // 1 = fetch granted, 0 = data granted
        logic [31:0] exp_addr;
        logic        exp_wen;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Records the type of the next n grants. With lock_seq set, d_lock is
    // driven high for the first 7 data transactions and low afterwards.
    task automatic observe(input int n, input bit lock_seq);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 8 * n + 20) begin
            if (!m_req && lock_seq) d_lock = (got < 7);
            step();
            cyc++;
            if (m_req) begin
                grant_is_i[got] = (m_addr == I_ADDR);
                $display("grant %0d: %s addr=0x%08h", got, grant_is_i[got] ? "I" : "D", m_addr);
                got++;
            end
        end
        if (got < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL grant timeout: got %0d grants expected %0d", got, n);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 1'b1, 4'hF, 32'h0000_4444, 32'hDEAD_BEEF,
                    1, 32'h0000_0013, 1'b1, 32'h0000_0100, 1'b0, 4'h0, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0200, 1'b1, 1'b1, 4'b0011, 32'h8000_0004, 32'hBEEF_BEEF,
                    2, 32'h0, 1'b0, 32'h8000_0004, 1'b1, 4'b0011, 32'hBEEF_BEEF};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_2000, 32'h0,
                    0, 32'hCAFE_F00D, 1'b0, 32'h0000_2000, 1'b0, 4'h0, 32'h0};
        vecs[3] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                    0, 32'h1234_5678, 1'b1, 32'hFFFF_FFFC, 1'b0, 4'h0, 32'h0};
        vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'b1100, 32'h0000_0010, 32'h0A0B_0C0D,
                    3, 32'h0, 1'b0, 32'h0000_0010, 1'b1, 4'b1100, 32'h0A0B_0C0D};

        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wen = 1'b0;
        d_strb = '0; d_addr = '0; d_wdata = '0; d_lock = 1'b0; m_rdata = '0;
        mem_auto = 1'b0; m_ready_man = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst m_req",   m_req,   0);
        chk("rst m_wen",   m_wen,   0);
        chk("rst m_strb",  m_strb,  0);
        chk("rst m_addr",  m_addr,  0);
        chk("rst m_wdata", m_wdata, 0);
        chk("rst i_ready", i_ready, 0);
        chk("rst d_ready", d_ready, 0);
        rst = 1'b0;
        step();

        // ---------------- single transactions from the table ----------------
        for (int v = 0; v < 5; v++) begin
            // m_ready in IDLE must be ignored
            m_ready_man = 1'b1;
            #1;
            chk($sformatf("v%0d idle i_ready", v), i_ready, 0);
            chk($sformatf("v%0d idle d_ready", v), d_ready, 0);
            step();
            chk($sformatf("v%0d idle m_req", v), m_req, 0);
            m_ready_man = 1'b0;

            i_req = vecs[v].i_req;   i_addr = vecs[v].i_addr;
            d_req = vecs[v].d_req;   d_wen = vecs[v].d_wen;
            d_strb = vecs[v].d_strb; d_addr = vecs[v].d_addr;
            d_wdata = vecs[v].d_wdata;
            step();
            chk($sformatf("v%0d m_req", v),   m_req,   1);
            chk($sformatf("v%0d m_addr", v),  m_addr,  vecs[v].exp_addr);
            chk($sformatf("v%0d m_wen", v),   m_wen,   vecs[v].exp_wen);
            chk($sformatf("v%0d m_strb", v),  m_strb,  vecs[v].exp_strb);
            chk($sformatf("v%0d m_wdata", v), m_wdata, vecs[v].exp_wdata);

            // payload changes after the grant must not reach the memory side
            i_addr = ~i_addr; d_addr = ~d_addr; d_wdata = ~d_wdata;
            for (int w = 0; w < vecs[v].wait_cyc; w++) begin
                #1;
                chk($sformatf("v%0d wait i_ready", v), i_ready, 0);
                chk($sformatf("v%0d wait d_ready", v), d_ready, 0);
                step();
            end

            m_ready_man = 1'b1;
            m_rdata = vecs[v].rdata;
            #1;
            chk($sformatf("v%0d i_ready", v), i_ready, vecs[v].exp_i);
            chk($sformatf("v%0d d_ready", v), d_ready, !vecs[v].exp_i);
            chk($sformatf("v%0d rdata", v), vecs[v].exp_i ? i_rdata : d_rdata, vecs[v].rdata);
            chk($sformatf("v%0d m_addr held", v), m_addr, vecs[v].exp_addr);
            chk($sformatf("v%0d m_wdata held", v), m_wdata, vecs[v].exp_wdata);
            $display("vec %0d: %s addr=0x%08h wen=%0b strb=%b rdata=0x%08h",
                     v, vecs[v].exp_i ? "fetch" : "data", m_addr, m_wen, m_strb, vecs[v].rdata);
            step();
            i_req = 1'b0; d_req = 1'b0; m_ready_man = 1'b0;
            chk($sformatf("v%0d end m_req", v), m_req, 0);
            chk($sformatf("v%0d end i_ready", v), i_ready, 0);
        end

        // ---------------- simultaneous first requests ----------------
        d_wen = 1'b0; d_strb = '0; d_wdata = '0;
        i_req = 1'b1; i_addr = I_ADDR; d_req = 1'b1; d_addr = D_ADDR;
        step();
        chk("sim first m_addr", m_addr, D_ADDR);
        chk("sim first m_wen", m_wen, 0);
        m_ready_man = 1'b1; m_rdata = 32'h0000_0055;
        #1;
        chk("sim d_ready", d_ready, 1);
        chk("sim i_ready early", i_ready, 0);
        chk("sim d_rdata", d_rdata, 32'h0000_0055);
        step();
        d_req = 1'b0; m_ready_man = 1'b0;
        chk("sim gap m_req", m_req, 0);
        step();
        chk("sim second m_req", m_req, 1);
        chk("sim second m_addr", m_addr, I_ADDR);
        m_ready_man = 1'b1;
        #1;
        chk("sim i_ready", i_ready, 1);
        $display("simultaneous: data then fetch");
        step();
        i_req = 1'b0; m_ready_man = 1'b0;
        step();

        // ---------------- starvation ----------------
        i_req = 1'b1; d_req = 1'b1; mem_auto = 1'b1;
        observe(10, 1'b0);
        for (int k = 0; k < 10; k++)
            chk($sformatf("starve grant %0d is_i", k), grant_is_i[k], (k % 5) == 4);
        step();
        i_req = 1'b0; d_req = 1'b0; mem_auto = 1'b0;
        step();

        // ---------------- lock ----------------
        i_req = 1'b1; d_req = 1'b1; mem_auto = 1'b1;
        observe(9, 1'b1);
        for (int k = 0; k < 9; k++) begin
`ifdef MEM_ARB_LOCK_EN
            chk($sformatf("lock grant %0d is_i", k), grant_is_i[k], k == 8);
`else
            chk($sformatf("lock grant %0d is_i", k), grant_is_i[k], k == 4);
`endif
        end
        step();
        d_lock = 1'b0; i_req = 1'b0; d_req = 1'b0; mem_auto = 1'b0;
        step();

        // ---------------- reset mid-transaction ----------------
        // A lone fetch clears the counter, then three data grants with fetch
        // waiting bring it to 3; the fourth data grant is interrupted by reset.
        i_req = 1'b1; mem_auto = 1'b1;
        observe(1, 1'b0);
        chk("pre-rst fetch", grant_is_i[0], 1);
        d_req = 1'b1;
        observe(3, 1'b0);
        for (int k = 0; k < 3; k++)
            chk($sformatf("pre-rst grant %0d is_i", k), grant_is_i[k], 0);
        step();
        mem_auto = 1'b0; m_ready_man = 1'b0;
        step();
        chk("pre-rst busy m_req", m_req, 1);
        chk("pre-rst busy m_addr", m_addr, D_ADDR);
        rst = 1'b1;
        #1;
        chk("rst busy d_ready", d_ready, 0);
        step();
        chk("after rst m_req", m_req, 0);
        chk("after rst d_ready", d_ready, 0);
        chk("after rst m_addr", m_addr, 0);
        rst = 1'b0; mem_auto = 1'b1;
        // counter must restart at 0: four data grants before the fetch
        observe(5, 1'b0);
        for (int k = 0; k < 5; k++)
            chk($sformatf("post-rst grant %0d is_i", k), grant_is_i[k], k == 4);
        step();

        // ---------------- reset and m_ready in the same cycle ----------------
        i_req = 1'b0; mem_auto = 1'b0; m_ready_man = 1'b0;
        step();
        chk("rst+ready busy m_req", m_req, 1);
        rst = 1'b1; m_ready_man = 1'b1;
        #1;
        chk("rst+ready d_ready", d_ready, 1);
        step();
        rst = 1'b0; m_ready_man = 1'b0; d_req = 1'b0;
        chk("rst+ready m_req", m_req, 0);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
